dbg_port_arbiter: RTL and testbench
===================================

Name: dbg_port_arbiter

Overview:
- Shares the core's single debug command port (cmd/addr/data in, data/ready out) between NREQ independent requesters, e.g. the external host bridge and an on-chip UART program loader.
- Grants one requester at a time using round-robin.
- Latches the granted command and drives it to the core until the core signals ready.
- Returns read data and a one-cycle done pulse to the granted requester, with a timeout guard against a hung debug unit.

Parameters:
- NREQ, 2, number of requesters (2..4)
- TIMEOUT, 1024, cycles waited in BUSY for dbg_ready_i before aborting; 0 disables the timeout
- ERR_DATA, 32'hDEADBEEF, value returned on rdata_o when a command times out

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  reset, synchronous, active-low
- req_i  in  NREQ  per-requester request; held high until that requester's done pulse
- req_cmd_i  in  NREQ*8  per-requester command, packed, requester n at [8n+7:8n]; 8'h00 is NOP
- req_addr_i  in  NREQ*32  per-requester address, packed
- req_data_i  in  NREQ*32  per-requester write data, packed
- gnt_o  out  NREQ  one-hot; currently granted requester, held from latch until done
- done_o  out  NREQ  one-cycle pulse to the granted requester at completion
- err_o  out  1  valid with done_o; 1 means the command timed out
- rdata_o  out  32  result data; valid in the done_o cycle, held until the next completion
- busy_o  out  1  high in BUSY and DRAIN
- dbg_cmd_o  out  8  command to core debug unit
- dbg_addr_o  out  32  address to core debug unit
- dbg_data_o  out  32  write data to core debug unit
- dbg_data_i  in  32  read data from core debug unit
- dbg_ready_i  in  1  core debug unit completed current command

Behaviour:
- Interface: one clock, clk_i; reset rstn_i is synchronous and active-low. All outputs are registered.
- Reset values: gnt_o=0, done_o=0, err_o=0, rdata_o=0, busy_o=0, dbg_cmd_o=0, dbg_addr_o=0, dbg_data_o=0, timeout counter=0. last_grant=NREQ-1, so requester 0 wins first. State=IDLE.
- Reset mid-operation: the in-flight command is dropped, with no done pulse. dbg_cmd_o returns to NOP in the cycle after reset is sampled.

State machine: IDLE, BUSY, DRAIN.

IDLE:
- dbg_cmd_o=0.
- When any req_i bit is high, select the first set bit scanning from last_grant+1 upward, with wrap-around.
- Latch that requester's cmd/addr/data into the dbg_*_o registers. Set gnt_o one-hot and last_grant, clear the counter, go to BUSY.
- Latency: req_i high at cycle t gives dbg_cmd_o valid at t+1.
- If the latched cmd is 8'h00, skip the core entirely. Go to DRAIN with done_o pulse, err_o=0, rdata_o unchanged.

BUSY:
- dbg_* outputs are held stable. Requester inputs are ignored, so a requester may change them after gnt_o.
- dbg_ready_i sampled high:
  - rdata_o<=dbg_data_i, done_o[g]<=1, err_o<=0.
  - dbg_cmd_o<=0, go to DRAIN.
- Else counter increments. When counter==TIMEOUT-1 with TIMEOUT!=0 and still no ready:
  - rdata_o<=ERR_DATA, done_o[g]<=1, err_o<=1.
  - dbg_cmd_o<=0, go to DRAIN.
- ready and timeout in the same cycle: ready wins, err_o=0.

DRAIN:
- One cycle with dbg_cmd_o=0, so the core debug unit sees NOP and releases ready.
- gnt_o cleared, done_o cleared, go to IDLE.
- Earliest next dbg_cmd_o: 3 cycles after the ready cycle.

Requester rules:
- A requester dropping req_i before being granted is withdrawn without side effects.
- Dropping req_i while granted has no effect; the command completes.
- A requester keeping req_i high after done is treated as a new request. Round-robin still gives other pending requesters priority.

Fairness:
- With all NREQ requesting continuously, grants rotate 0,1,..,NREQ-1,0.
- No requester waits more than NREQ-1 transactions.

Test Plan:
- Reset then single request: req_i=01, cmd=8'h02, addr=32'h100, data=32'hA5; core returns ready 4 cycles later with dbg_data_i=32'h1234 -> dbg_cmd_o=02 on the cycle after req; done_o=01, rdata_o=32'h1234, err_o=0; dbg_cmd_o=0 in DRAIN.
- Both requesting from reset, ready after 2 cycles each -> grant order 0,1,0,1; gnt_o never two-hot; dbg_cmd_o=0 for exactly 2 cycles between commands.
- Requester 1 changes req_cmd_i/addr while granted -> dbg_cmd_o/addr stay at the latched values until done.
- TIMEOUT=8, dbg_ready_i never asserted -> done_o pulse 8 cycles after entering BUSY, err_o=1, rdata_o=32'hDEADBEEF; the next request is served normally.
- ready asserted in exactly the timeout cycle -> err_o=0, rdata_o=dbg_data_i.
- rstn_i low in the middle of BUSY -> next cycle all outputs 0; no done_o pulse; the first grant after release goes to requester 0.

Source files
------------

// File: rtl/dbg_port_arbiter.sv
// dbg_port_arbiter
//   Round-robin share of the core's single debug command port between NREQ
//   requesters. In IDLE the winning requester's command is latched and driven
//   to the core. The core's ready ends BUSY, and a cycle counter can abort a
//   hung debug unit. The unit then spends one DRAIN cycle on NOP so the core
//   can drop ready. A NOP command (8'h00) bypasses the core and completes at once.
//
// Ports
//   clk_i, rstn_i             clock, synchronous active-low reset
//   req_i[NREQ]               per-requester request, held until its done pulse
//   req_cmd_i/addr_i/data_i   packed per-requester command/address/write data
//   gnt_o[NREQ]               one-hot grant, held from latch until DRAIN ends
//   done_o[NREQ]              one-cycle completion pulse to the granted requester
//   err_o                     with done_o: 1 = command timed out
//   rdata_o                   result data, held until the next completion
//   busy_o                    high in BUSY and DRAIN
//   dbg_cmd_o/addr_o/data_o   command to the core debug unit
//   dbg_data_i, dbg_ready_i   response from the core debug unit
module dbg_port_arbiter #(
   parameter int          NREQ     = 2,
   parameter int          TIMEOUT  = 1024,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic [NREQ-1:0]      req_i,
   input  logic [NREQ*8-1:0]    req_cmd_i,
   input  logic [NREQ*32-1:0]   req_addr_i,
   input  logic [NREQ*32-1:0]   req_data_i,
   output logic [NREQ-1:0]      gnt_o,
   output logic [NREQ-1:0]      done_o,
   output logic                 err_o,
   output logic [31:0]          rdata_o,
   output logic                 busy_o,
   output logic [7:0]           dbg_cmd_o,
   output logic [31:0]          dbg_addr_o,
   output logic [31:0]          dbg_data_o,
   input  logic [31:0]          dbg_data_i,
   input  logic                 dbg_ready_i
);

   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_t;

   state_t            state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic              err_q, err_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              busy_q, busy_d;
   logic [7:0]        cmd_q, cmd_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [GW-1:0]     last_q, last_d;

   logic              sel_found;
   logic [GW-1:0]     sel_idx;
   logic [7:0]        sel_cmd;
   logic [NREQ-1:0]   sel_oh;

   // (base + k) mod NREQ, i.e. the k-th requester after base with wrap-around
   function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int k);
      int s;
      s = (int'(base) + k) % NREQ;
      return GW'(s);
   endfunction

   // Round-robin pick: scan starting one past the last grant, so the last
   // winner is checked last and cannot starve anyone.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!sel_found && req_i[wrap_idx(last_q, k)]) begin
            sel_found = 1'b1;
            sel_idx   = wrap_idx(last_q, k);
         end
      end
      sel_cmd = req_cmd_i[8*sel_idx +: 8];
      sel_oh  = {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      err_d   = err_q;
      rdata_d = rdata_q;
      cmd_d   = cmd_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      case (state_q)
         S_IDLE: begin
            cmd_d = 8'h00;
            if (sel_found) begin
               cmd_d   = sel_cmd;
               addr_d  = req_addr_i[32*sel_idx +: 32];
               wdata_d = req_data_i[32*sel_idx +: 32];
               gnt_d   = sel_oh;
               last_d  = sel_idx;
               cnt_d   = '0;
               if (sel_cmd == 8'h00) begin
                  // NOP never reaches the core; rdata is left untouched
                  done_d  = sel_oh;
                  err_d   = 1'b0;
                  state_d = S_DRAIN;
               end else begin
                  state_d = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            // ready is checked first so it beats a coincident timeout
            if (dbg_ready_i) begin
               rdata_d = dbg_data_i;
               done_d  = gnt_q;
               err_d   = 1'b0;
               cmd_d   = 8'h00;
               state_d = S_DRAIN;
            end else if (TIMEOUT != 0 && cnt_q == TMAX) begin
               rdata_d = ERR_DATA;
               done_d  = gnt_q;
               err_d   = 1'b1;
               cmd_d   = 8'h00;
               state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DRAIN: begin
            gnt_d   = '0;
            cmd_d   = 8'h00;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         done_q  <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         busy_q  <= 1'b0;
         cmd_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         last_q  <= GW'(NREQ - 1);
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         busy_q  <= busy_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   assign gnt_o      = gnt_q;
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign rdata_o    = rdata_q;
   assign busy_o     = busy_q;
   assign dbg_cmd_o  = cmd_q;
   assign dbg_addr_o = addr_q;
   assign dbg_data_o = wdata_q;

endmodule

// File: tb/tb_dbg_port_arbiter.sv
// Bench for dbg_port_arbiter (NREQ=2, TIMEOUT=8). A small core model answers
// commands after core_delay cycles (0 = never). Expected completions are
// queued when a request is driven, and the monitor checks them on done_o.
module tb_dbg_port_arbiter;
   localparam int NREQ = 2;

   logic               clk_i = 1'b0;
   logic               rstn_i;
   logic [NREQ-1:0]    req_i;
   logic [NREQ*8-1:0]  req_cmd_i;
   logic [NREQ*32-1:0] req_addr_i;
   logic [NREQ*32-1:0] req_data_i;
   logic [NREQ-1:0]    gnt_o;
   logic [NREQ-1:0]    done_o;
   logic               err_o;
   logic [31:0]        rdata_o;
   logic               busy_o;
   logic [7:0]         dbg_cmd_o;
   logic [31:0]        dbg_addr_o;
   logic [31:0]        dbg_data_o;
   logic [31:0]        dbg_data_i;
   logic               dbg_ready_i;

   dbg_port_arbiter #(.NREQ(NREQ), .TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .req_i(req_i), .req_cmd_i(req_cmd_i),
      .req_addr_i(req_addr_i), .req_data_i(req_data_i), .gnt_o(gnt_o),
      .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .busy_o(busy_o),
      .dbg_cmd_o(dbg_cmd_o), .dbg_addr_o(dbg_addr_o), .dbg_data_o(dbg_data_o),
      .dbg_data_i(dbg_data_i), .dbg_ready_i(dbg_ready_i));

   initial forever #5 clk_i = ~clk_i;

   typedef struct {
      int          n;
      logic [7:0]  cmd;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          n_chk = 0;
   int          n_fail = 0;
   int          core_delay = 4;
   int          busy_cyc = 0;
   logic [31:0] last_rdata = '0;
   logic        gap_en = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // core debug unit model: ready for one cycle, core_delay cycles into a command
   initial begin
      dbg_ready_i = 1'b0;
      dbg_data_i  = '0;
      forever begin
         @(negedge clk_i);
         if (dbg_cmd_o != 8'h00) begin
            busy_cyc++;
            if (core_delay != 0 && busy_cyc == core_delay) begin
               dbg_ready_i = 1'b1;
               dbg_data_i  = dbg_addr_o ^ 32'h0000_1334;
            end else begin
               dbg_ready_i = 1'b0;
            end
         end else begin
            busy_cyc    = 0;
            dbg_ready_i = 1'b0;
         end
      end
   end

   // monitor: grant sanity, command stability, NOP gap, completion scoreboard
   initial begin
      logic [7:0]  cap_cmd, prev_cmd;
      logic [31:0] cap_addr, cap_data;
      int cyc, start_cyc, gap, en_rises;
      cap_cmd = '0; prev_cmd = '0; cap_addr = '0; cap_data = '0;
      cyc = 0; start_cyc = 0; gap = 0; en_rises = 0;
      forever begin
         @(negedge clk_i);
         cyc++;
         chk("gnt_onehot0", 32'($onehot0(gnt_o)), 32'd1);
         if (!gap_en) en_rises = 0;
         if (dbg_cmd_o != 8'h00) begin
            if (prev_cmd == 8'h00) begin
               cap_cmd = dbg_cmd_o; cap_addr = dbg_addr_o; cap_data = dbg_data_o;
               start_cyc = cyc;
               if (gap_en) begin
                  if (en_rises > 0) chk("nop_gap", gap, 2);
                  en_rises++;
               end
            end else begin
               chk("hold_cmd", dbg_cmd_o, cap_cmd);
               chk("hold_addr", dbg_addr_o, cap_addr);
               chk("hold_data", dbg_data_o, cap_data);
            end
            gap = 0;
         end else begin
            gap++;
         end
         prev_cmd = dbg_cmd_o;
         if (done_o != '0) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", done_o, 0);
            end else begin
               e = sb.pop_front();
               chk("done_vec", done_o, 32'(1) << e.n);
               chk("err", err_o, e.err);
               chk("rdata", rdata_o, e.rdata);
               chk("drain_cmd", dbg_cmd_o, 0);
               chk("drain_busy", busy_o, 1);
               if (e.cmd != 8'h00) begin
                  chk("lat_cmd", cap_cmd, e.cmd);
                  chk("lat_addr", cap_addr, e.addr);
                  chk("lat_data", cap_data, e.data);
               end
               if (e.lat != 0) chk("done_latency", cyc - start_cyc, e.lat);
            end
         end
      end
   end

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "_gnt"}, gnt_o, 0);
      chk({pfx, "_done"}, done_o, 0);
      chk({pfx, "_err"}, err_o, 0);
      chk({pfx, "_rdata"}, rdata_o, 0);
      chk({pfx, "_busy"}, busy_o, 0);
      chk({pfx, "_cmd"}, dbg_cmd_o, 0);
      chk({pfx, "_addr"}, dbg_addr_o, 0);
      chk({pfx, "_data"}, dbg_data_o, 0);
   endtask

   task automatic do_single(input int n, input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data, input logic err, input logic [31:0] rdata,
                            input int lat, input logic chg);
      logic got;
      sb.push_back('{n, cmd, addr, data, rdata, err, lat});
      last_rdata = rdata;
      req_cmd_i[8*n +: 8]   = cmd;
      req_addr_i[32*n +: 32] = addr;
      req_data_i[32*n +: 32] = data;
      req_i[n] = 1'b1;
      @(negedge clk_i);
      if (cmd != 8'h00) chk("cmd_latency", dbg_cmd_o, cmd);
      else              chk("nop_cmd", dbg_cmd_o, 0);
      chk("gnt", gnt_o, 32'(1) << n);
      if (chg) begin
         req_cmd_i[8*n +: 8]    = ~cmd;
         req_addr_i[32*n +: 32] = ~addr;
         req_data_i[32*n +: 32] = ~data;
      end
      got = 1'b0;
      for (int i = 0; i < 64 && !got; i++) begin
         if (done_o[n]) got = 1'b1;
         else @(negedge clk_i);
      end
      if (!got) chk("done_wait", 0, 1);
      req_i[n] = 1'b0;
      @(negedge clk_i);
   endtask

   function automatic logic [7:0] jcmd(input int n, input int j);
      return 8'(8'h10 + 2*j + n);
   endfunction
   function automatic logic [31:0] jaddr(input int n, input int j);
      return 32'h1000 + 32'(n << 8) + 32'(j * 4);
   endfunction

   // both requesters issue `jobs` commands, re-requesting right after each done
   task automatic run_two(input int jobs);
      int cnt [NREQ];
      for (int j = 0; j < jobs; j++)
         for (int n = 0; n < NREQ; n++) begin
            sb.push_back('{n, jcmd(n, j), jaddr(n, j), ~jaddr(n, j),
                           jaddr(n, j) ^ 32'h0000_1334, 1'b0, 0});
            last_rdata = jaddr(n, j) ^ 32'h0000_1334;
         end
      for (int n = 0; n < NREQ; n++) begin
         cnt[n] = 0;
         req_cmd_i[8*n +: 8]    = jcmd(n, 0);
         req_addr_i[32*n +: 32] = jaddr(n, 0);
         req_data_i[32*n +: 32] = ~jaddr(n, 0);
      end
      req_i = '1;
      for (int i = 0; i < 400 && req_i != '0; i++) begin
         @(negedge clk_i);
         for (int n = 0; n < NREQ; n++)
            if (req_i[n] && done_o[n]) begin
               cnt[n]++;
               if (cnt[n] == jobs) req_i[n] = 1'b0;
               else begin
                  req_cmd_i[8*n +: 8]    = jcmd(n, cnt[n]);
                  req_addr_i[32*n +: 32] = jaddr(n, cnt[n]);
                  req_data_i[32*n +: 32] = ~jaddr(n, cnt[n]);
               end
            end
      end
      if (req_i != '0) chk("run_two_wait", 0, 1);
      req_i = '0;
      @(negedge clk_i);
   endtask

   initial begin
      rstn_i = 1'b0; req_i = '0; req_cmd_i = '0; req_addr_i = '0; req_data_i = '0;
      repeat (3) @(negedge clk_i);
      chk_all_zero("rst");
      rstn_i = 1'b1;
      @(negedge clk_i);

      core_delay = 4;
      do_single(0, 8'h02, 32'h100, 32'hA5, 1'b0, 32'h0000_1234, 4, 1'b0);
      do_single(1, 8'h05, 32'h300, 32'h77, 1'b0, 32'h300 ^ 32'h1334, 4, 1'b1);
      do_single(1, 8'h00, 32'h400, 32'h0, 1'b0, last_rdata, 0, 1'b0);

      core_delay = 0;
      do_single(0, 8'h03, 32'h500, 32'h1, 1'b1, 32'hDEADBEEF, 8, 1'b0);
      core_delay = 4;
      do_single(1, 8'h04, 32'h600, 32'h2, 1'b0, 32'h600 ^ 32'h1334, 4, 1'b0);
      core_delay = 8;
      do_single(0, 8'h06, 32'h700, 32'h3, 1'b0, 32'h700 ^ 32'h1334, 8, 1'b0);

      rstn_i = 1'b0;
      @(negedge clk_i);
      rstn_i = 1'b1;
      @(negedge clk_i);
      core_delay = 2;
      gap_en = 1'b1;
      run_two(2);
      gap_en = 1'b0;

      // requester 0 hangs in BUSY and is cut off by reset; no completion queued
      core_delay = 0;
      req_cmd_i[7:0] = 8'h09; req_addr_i[31:0] = 32'h800; req_data_i[31:0] = 32'h9;
      req_i = 2'b01;
      repeat (3) @(negedge clk_i);
      chk("mid_busy", busy_o, 1);
      rstn_i = 1'b0;
      @(negedge clk_i);
      chk_all_zero("midrst");
      req_i = '0;
      @(negedge clk_i);
      rstn_i = 1'b1;
      core_delay = 2;
      run_two(1);

      repeat (5) @(negedge clk_i);
      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 0 expected 1");
      $fatal(1, "bench time limit");
   end

endmodule
